// File: rtl/poly_mixer_if.sv
// Voice-bank to mixer bus: voice inputs, request/clear strobes and mixed result with status flags.
interface poly_mixer_if #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 24,
    parameter int VOL_W      = 8
);
    logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples;
    logic [NUM_VOICES-1:0]          voice_enable;
    logic [VOL_W-1:0]               master_vol;
    logic                           sample_req;
    logic                           flags_clear;
    logic signed [SAMPLE_W-1:0]     mixed_sample;
    logic                           mixed_valid;
    logic                           busy;
    logic                           clip_flag;
    logic                           overrun_flag;

    modport master (
        output voice_samples, voice_enable, master_vol, sample_req, flags_clear,
        input  mixed_sample, mixed_valid, busy, clip_flag, overrun_flag
    );

    modport slave (
        input  voice_samples, voice_enable, master_vol, sample_req, flags_clear,
        output mixed_sample, mixed_valid, busy, clip_flag, overrun_flag
    );
endinterface

// File: rtl/poly_mixer.sv
// N-voice mixer: serial accumulate of enabled voices, master-volume gain, saturation to SAMPLE_W.
module poly_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int SAMPLE_W   = 24,
    parameter int VOL_W      = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    poly_mixer_if.slave bus
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + IDX_W;
    localparam int PROD_W = ACC_W + VOL_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = (PROD_W'(1) <<< (SAMPLE_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, SAT} state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic signed [SAMPLE_W-1:0] voice_p0 [NUM_VOICES];
    logic [NUM_VOICES-1:0]      enable_p0;
    logic [VOL_W-1:0]           vol_p0;
    logic signed [ACC_W-1:0]    acc_p0;
    logic signed [PROD_W-1:0]   scaled_p1;
    logic signed [SAMPLE_W-1:0] mixed_p2;
    logic                       vld_p2;
    logic                       clip_q;
    logic                       overrun_q;

    logic signed [ACC_W-1:0]    term;
    logic signed [PROD_W-1:0]   acc_ext;
    logic signed [PROD_W-1:0]   vol_ext;
    logic signed [PROD_W-1:0]   product;

    function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] c;
        c = v;
        if (v > SAT_MAX) c = SAT_MAX;
        if (v < SAT_MIN) c = SAT_MIN;
        return c[SAMPLE_W-1:0];
    endfunction

    function automatic logic is_clipped(input logic signed [PROD_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    always_comb begin
        term = '0;
        if (enable_p0[idx])
            term = {{(ACC_W-SAMPLE_W){voice_p0[idx][SAMPLE_W-1]}}, voice_p0[idx]};
        // Volume is an unsigned gain, so it enters the signed multiply zero-extended.
        acc_ext = {{(PROD_W-ACC_W){acc_p0[ACC_W-1]}}, acc_p0};
        vol_ext = {{(PROD_W-VOL_W){1'b0}}, vol_p0};
        product = acc_ext * vol_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            enable_p0 <= '0;
            vol_p0    <= '0;
            acc_p0    <= '0;
            scaled_p1 <= '0;
            mixed_p2  <= '0;
            vld_p2    <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) voice_p0[i] <= '0;
        end else begin
            vld_p2 <= 1'b0;
            // Clear first so a same-cycle set event below takes precedence.
            if (bus.flags_clear) begin
                clip_q    <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (bus.sample_req && state != IDLE) overrun_q <= 1'b1;

            case (state)
                // p0: latch inputs on request
                IDLE: begin
                    if (bus.sample_req) begin
                        for (int i = 0; i < NUM_VOICES; i++)
                            voice_p0[i] <= bus.voice_samples[i*SAMPLE_W +: SAMPLE_W];
                        enable_p0 <= bus.voice_enable;
                        vol_p0    <= bus.master_vol;
                        acc_p0    <= '0;
                        idx       <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc_p0 <= acc_p0 + term;
                    idx    <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) state <= SCALE;
                end
                // p1: gain and floor-shift
                SCALE: begin
                    scaled_p1 <= product >>> (VOL_W - 1);
                    state     <= SAT;
                end
                // p2: clamp and publish
                SAT: begin
                    mixed_p2 <= saturate(scaled_p1);
                    vld_p2   <= 1'b1;
                    if (is_clipped(scaled_p1)) clip_q <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mixed_sample = mixed_p2;
    assign bus.mixed_valid  = vld_p2;
    assign bus.busy         = (state != IDLE);
    assign bus.clip_flag    = clip_q;
    assign bus.overrun_flag = overrun_q;

endmodule

// File: tb/tb_poly_mixer.sv
// Directed and randomised checks of poly_mixer with four voices.
module tb_poly_mixer;

    localparam int NV = 4;
    localparam int SW = 24;
    localparam int VW = 8;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    poly_mixer_if #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) bus ();

    poly_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOL_W(VW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic int mix_ref(input logic [NV*SW-1:0] vs, input logic [NV-1:0] en,
                                   input logic [VW-1:0] vol);
        longint sum;
        longint p;
        logic signed [SW-1:0] v;
        sum = 0;
        for (int i = 0; i < NV; i++) begin
            if (en[i]) begin
                v = vs[i*SW +: SW];
                sum += longint'(v);
            end
        end
        p = sum * longint'(vol);
        p = p >>> 7;
        if (p > 64'sd8388607) return 8388607;
        if (p < -64'sd8388608) return -8388608;
        return int'(p);
    endfunction

    task automatic set_voices(input int a, input int b, input int c, input int d);
        bus.voice_samples = {24'(d), 24'(c), 24'(b), 24'(a)};
    endtask

    // Called at a negedge; returns at the negedge where mixed_valid is seen (or budget expires).
    task automatic run_req(output int edges, output int sample);
        bus.sample_req = 1'b1;
        @(negedge clk);
        bus.sample_req = 1'b0;
        edges = 1;
        while (bus.mixed_valid !== 1'b1 && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        sample = int'(bus.mixed_sample);
    endtask

    task automatic pulse_clear();
        bus.flags_clear = 1'b1;
        @(negedge clk);
        bus.flags_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #5;
        checks++;
        if (bus.mixed_sample !== 24'sd0) begin
            failures++;
            $display("FAIL reset_sample: got %0d expected 0", bus.mixed_sample);
        end
        checks++;
        if ({bus.mixed_valid, bus.busy, bus.clip_flag, bus.overrun_flag} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {bus.mixed_valid, bus.busy, bus.clip_flag, bus.overrun_flag});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e, s;
        set_voices(1000, 2000, -500, 0);
        bus.voice_enable = 4'b1111;
        bus.master_vol   = 8'd128;
        run_req(e, s);
        checks++;
        if (e !== 7) begin failures++; $display("FAIL basic_latency: got %0d expected 7", e); end
        checks++;
        if (s !== 2500) begin failures++; $display("FAIL basic_value: got %0d expected 2500", s); end
        checks++;
        if (bus.clip_flag !== 1'b0) begin failures++; $display("FAIL basic_clip: got %b expected 0", bus.clip_flag); end
        @(negedge clk);
        checks++;
        if (bus.mixed_valid !== 1'b0 || int'(bus.mixed_sample) !== 2500) begin
            failures++;
            $display("FAIL basic_hold: valid=%b sample=%0d expected valid=0 sample=2500",
                     bus.mixed_valid, bus.mixed_sample);
        end
    endtask

    task automatic test_enable_mask();
        int e, s;
        set_voices(1000, 2000, -500, 0);
        bus.voice_enable = 4'b1011;
        bus.master_vol   = 8'd64;
        run_req(e, s);
        checks++;
        if (s !== 1500) begin failures++; $display("FAIL mask_1011: got %0d expected 1500", s); end
        set_voices(-2501, 0, 0, 0);
        bus.voice_enable = 4'b1111;
        run_req(e, s);
        checks++;
        if (s !== -1251) begin failures++; $display("FAIL floor_neg: got %0d expected -1251", s); end
        set_voices(1000, 2000, -500, 77);
        bus.voice_enable = 4'b0000;
        bus.master_vol   = 8'd128;
        run_req(e, s);
        checks++;
        if (e !== 7 || s !== 0) begin
            failures++;
            $display("FAIL all_disabled: edges=%0d sample=%0d expected edges=7 sample=0", e, s);
        end
        bus.voice_enable = 4'b1111;
        bus.master_vol   = 8'd0;
        run_req(e, s);
        checks++;
        if (s !== 0) begin failures++; $display("FAIL mute: got %0d expected 0", s); end
    endtask

    task automatic test_saturation();
        int e, s;
        set_voices(8388607, 8388607, 8388607, 8388607);
        bus.voice_enable = 4'b1111;
        bus.master_vol   = 8'd128;
        run_req(e, s);
        checks++;
        if (s !== 8388607 || bus.clip_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_pos: sample=%0d clip=%b expected 8388607 clip=1", s, bus.clip_flag);
        end
        pulse_clear();
        checks++;
        if (bus.clip_flag !== 1'b0) begin failures++; $display("FAIL clip_clear: got %b expected 0", bus.clip_flag); end
        // flags_clear coincides with the saturating edge: the flag must end up set.
        set_voices(-8388608, -8388608, -8388608, -8388608);
        bus.sample_req = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            bus.sample_req  = 1'b0;
            bus.flags_clear = (n == 6);
        end
        bus.flags_clear = 1'b0;
        checks++;
        if (bus.mixed_valid !== 1'b1 || int'(bus.mixed_sample) !== -8388608 || bus.clip_flag !== 1'b1) begin
            failures++;
            $display("FAIL sat_neg_setwins: valid=%b sample=%0d clip=%b expected 1 -8388608 1",
                     bus.mixed_valid, bus.mixed_sample, bus.clip_flag);
        end
        pulse_clear();
        checks++;
        if (bus.clip_flag !== 1'b0) begin failures++; $display("FAIL clip_clear2: got %b expected 0", bus.clip_flag); end
    endtask

    task automatic test_overrun();
        int vcount, vedge, vsample;
        set_voices(100, 200, 300, 400);
        bus.voice_enable = 4'b1111;
        bus.master_vol   = 8'd128;
        bus.sample_req   = 1'b1;
        vcount = 0; vedge = 0; vsample = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            bus.sample_req = (n == 3);
            if (n == 2) set_voices(-7, -7, -7, -7);
            if (bus.mixed_valid === 1'b1) begin
                vcount++;
                vedge   = n;
                vsample = int'(bus.mixed_sample);
            end
        end
        checks++;
        if (vcount !== 1 || vedge !== 7) begin
            failures++;
            $display("FAIL overrun_valids: count=%0d edge=%0d expected 1 at 7", vcount, vedge);
        end
        checks++;
        if (vsample !== 1000) begin failures++; $display("FAIL overrun_value: got %0d expected 1000", vsample); end
        checks++;
        if (bus.overrun_flag !== 1'b1) begin failures++; $display("FAIL overrun_flag: got %b expected 1", bus.overrun_flag); end
        pulse_clear();
        // A request landing on the saturate cycle is also an overrun.
        set_voices(100, 200, 300, 400);
        bus.sample_req = 1'b1;
        vcount = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            bus.sample_req = (n == 6);
            if (bus.mixed_valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 1 || bus.overrun_flag !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sat: valids=%0d flag=%b expected 1 and 1", vcount, bus.overrun_flag);
        end
        pulse_clear();
    endtask

    task automatic test_async_reset();
        int vcount, e, s;
        bus.sample_req = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            bus.sample_req = 1'b0;
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.mixed_sample !== 24'sd0 || bus.busy !== 1'b0 || bus.mixed_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: sample=%0d busy=%b valid=%b expected 0 0 0",
                     bus.mixed_sample, bus.busy, bus.mixed_valid);
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        vcount = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (bus.mixed_valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 0) begin failures++; $display("FAIL reset_abandon: valids=%0d expected 0", vcount); end
        run_req(e, s);
        checks++;
        if (e !== 7 || s !== 1000) begin
            failures++;
            $display("FAIL after_reset: edges=%0d sample=%0d expected 7 1000", e, s);
        end
    endtask

    task automatic test_back_to_back();
        logic [NV*SW-1:0] vs;
        logic [SW-1:0]    r;
        int exp, extra, bad;
        extra = 0;
        bad   = 0;
        for (int s = 0; s < 100; s++) begin
            for (int i = 0; i < NV; i++) begin
                r = 24'($urandom);
                if (s % 2 == 1) r = 24'($signed(r) >>> 3);
                vs[i*SW +: SW] = r;
            end
            bus.voice_samples = vs;
            bus.voice_enable  = 4'($urandom);
            bus.master_vol    = 8'($urandom);
            exp = mix_ref(vs, bus.voice_enable, bus.master_vol);
            bus.sample_req = 1'b1;
            for (int n = 1; n <= 7; n++) begin
                @(negedge clk);
                if (n == 1) begin
                    bus.sample_req    = 1'b0;
                    bus.voice_samples = {$urandom, $urandom, $urandom};
                    bus.master_vol    = 8'($urandom);
                end
                if (n < 7 && bus.mixed_valid === 1'b1) extra++;
            end
            checks++;
            if (bus.mixed_valid !== 1'b1 || int'(bus.mixed_sample) !== exp) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL b2b_sample%0d: valid=%b got %0d expected %0d",
                             s, bus.mixed_valid, bus.mixed_sample, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.overrun_flag !== 1'b0 || extra !== 0) begin
            failures++;
            $display("FAIL b2b_overrun: flag=%b stray_valids=%0d expected 0 0", bus.overrun_flag, extra);
        end
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.voice_samples = '0;
        bus.voice_enable  = '0;
        bus.master_vol    = '0;
        bus.sample_req    = 1'b0;
        bus.flags_clear   = 1'b0;
        test_reset();
        test_basic();
        test_enable_mask();
        test_saturation();
        test_overrun();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_mixer.md
Name: poly_mixer

Overview:
- Parametrised N-voice audio mixer; successor to the fixed 4-input mixer.
- Sits between the bank of NUM_VOICES waveform generators and the I2S transmitter.
- On each sample request it sums the enabled voices through a time-multiplexed accumulator, then applies the master-volume gain and saturates to SAMPLE_W.
- Reports clipping and request overruns to the NIOS-II through sticky flags.

Parameters:
- NUM_VOICES, 8: number of voice inputs (2..32).
- SAMPLE_W, 24: signed sample width of the voice inputs and of the output.
- VOL_W, 8: master volume width. Gain = master_vol / 2^(VOL_W-1), so 128 is unity, 0 is mute and 255 is about 1.99x.

Ports:
- clk, input, 1: system clock (50 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- voice_samples, input, NUM_VOICES*SAMPLE_W: signed voice samples; voice i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- voice_enable, input, NUM_VOICES: 1 = include voice i in the sum.
- master_vol, input, VOL_W: unsigned master gain.
- sample_req, input, 1: single-cycle request for a new mixed sample (from the I2S frame edge).
- mixed_sample, output, SAMPLE_W: signed, saturated mix result.
- mixed_valid, output, 1: one-cycle pulse when mixed_sample updates.
- busy, output, 1: high whenever the state is not IDLE.
- clip_flag, output, 1: sticky; set when saturation occurred.
- overrun_flag, output, 1: sticky; set when sample_req arrived while busy.
- flags_clear, input, 1: synchronous clear of clip_flag and overrun_flag.

Behaviour:
- Reset: asynchronous, reset_n low. All outputs go to 0 and the state goes to IDLE; accumulator, index and latched inputs clear. Reset mid-operation abandons the mix, and no mixed_valid is produced.
- Accumulator width: ACC_W = SAMPLE_W + clog2(NUM_VOICES); sign-extend every term into it. Product width: ACC_W + VOL_W + 1, with master_vol zero-extended as a positive operand.
- FSM states: IDLE, ACCUM, SCALE, SAT.
- IDLE:
  - On sample_req = 1, latch voice_samples, voice_enable and master_vol.
  - Clear the accumulator and set index to 0; go to ACCUM.
  - Inputs may change freely after that latch edge.
- ACCUM:
  - Each cycle, acc += latched_sample[index] if latched_enable[index], else += 0.
  - index increments each cycle; after index = NUM_VOICES-1, go to SCALE. ACCUM therefore lasts exactly NUM_VOICES cycles.
- SCALE: register product = acc * master_vol, then shift right arithmetically by VOL_W-1 (floor toward minus infinity); go to SAT.
- SAT:
  - Clamp the shifted product to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1] and register it into mixed_sample.
  - Pulse mixed_valid for one cycle; set clip_flag if the clamp was active; return to IDLE.
- Latency: mixed_valid is high during the cycle following the (NUM_VOICES+2)th rising edge after the edge that sampled sample_req, i.e. NUM_VOICES+3 edges total. For NUM_VOICES = 4 that is 7 edges. Throughput is one sample per NUM_VOICES+3 cycles minimum.
- mixed_sample holds its value between pulses.
- sample_req while busy:
  - The request is ignored and does not restart the mix; overrun_flag is set.
  - sample_req in the SAT cycle also counts as overrun.
  - sample_req in IDLE the cycle after SAT is accepted normally.
- Flag precedence: flags_clear and a new set event in the same cycle leave the flag set (set wins).
- Accumulator never overflows by construction; only the post-gain result saturates.
- An all-disabled voice_enable mask yields mixed_sample = 0 with a normal mixed_valid pulse.

Test Plan:
1. NUM_VOICES=4; voices {1000, 2000, -500, 0}, all enabled, master_vol=128, single sample_req. Required: mixed_valid exactly 7 edges later, mixed_sample = 2500, clip_flag = 0.
2. Same voices with voice_enable = 4'b1011 (voice 2 disabled), master_vol=64. Required: (1000+2000+0)*64 >>> 7 = 1500. Then voices sum to -2501 at master_vol=64. Required: -1251 (floor).
3. All four voices = 8388607, enabled, master_vol=128. Required: mixed_sample = 8388607, clip_flag = 1. All voices = -8388608. Required: mixed_sample = -8388608. flags_clear then returns clip_flag to 0.
4. Second sample_req 3 cycles after the first. Required: only one mixed_valid at edge 7, overrun_flag = 1, result matches the first request's latched inputs. Change voice_samples during ACCUM. Required: result unaffected.
5. Assert reset_n low during ACCUM. Required: outputs 0 immediately (asynchronous), no mixed_valid, busy = 0. A next sample_req after release completes normally.
6. Back-to-back requests spaced exactly NUM_VOICES+3 cycles apart over 100 samples of random voices, enables and volume. Required: every result matches the reference model, and overrun_flag stays 0.
